// File: rtl/sub_bytes_if.sv
// Request/response bundle between a state producer and the sub_bytes_engine.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
`timescale 1ns/1ps
interface sub_bytes_if;
    logic [127:0] inputData;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] byteSubData;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output inputData, enable, in_valid, out_ready,
        input  in_ready, byteSubData, out_valid, busy
    );

    modport slave (
        input  inputData, enable, in_valid, out_ready,
        output in_ready, byteSubData, out_valid, busy
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// AES SubBytes over a 128-bit state, one 32-bit word per cycle through four
// shared forward S-box lookups; enable=0 passes the state straight through.
`timescale 1ns/1ps
module sub_bytes_engine (
    input  logic       clk,
    input  logic       rst,
    sub_bytes_if.slave bus,
    output logic [1:0] o_dbg_state,
    output logic       o_dbg_mode
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX[b];
    endfunction

    state_t       r_state;
    logic [127:0] r_data;
    logic [1:0]   r_cnt;
    logic         r_mode;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [31:0]  w_word;
    logic [31:0]  w_sub_word;

    // The word counter selects which 32-bit slice the shared lookups see.
    assign w_word = r_data[{r_cnt, 5'd0} +: 32];

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub_word[8*g +: 8] = sbox_fwd(w_word[8*g +: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_data      <= 128'h0;
            r_cnt       <= 2'd0;
            r_mode      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_data     <= bus.inputData;
                        r_mode     <= bus.enable;
                        r_cnt      <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (bus.enable) begin
                            r_state <= ST_SUB;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_SUB: begin
                    r_data[{r_cnt, 5'd0} +: 32] <= w_sub_word;
                    r_cnt <= r_cnt + 2'd1;
                    // Counter wraps to 0 on the same edge that leaves SUB.
                    if (r_cnt == 2'd3) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 2'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.byteSubData = r_data;
    assign o_dbg_state     = r_state;
    assign o_dbg_mode      = r_mode;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed self-checking bench for sub_bytes_engine.
`timescale 1ns/1ps
module tb_sub_bytes_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dbg_state;
    logic       dbg_mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];

    sub_bytes_if sbif ();

    sub_bytes_engine dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (sbif.slave),
        .o_dbg_state (dbg_state),
        .o_dbg_mode  (dbg_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one state; returns one tick after the acceptance edge.
    task automatic send(input logic [127:0] d, input logic en);
        sbif.inputData = d;
        sbif.enable    = en;
        sbif.in_valid  = 1'b1;
        tick();
        sbif.in_valid  = 1'b0;
        sbif.inputData = ~d;
        sbif.enable    = ~en;
    endtask

    // Edges after the acceptance edge until out_valid is seen, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!sbif.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        sbif.out_ready = 1'b1;
        tick();
        sbif.out_ready = 1'b0;
        check("post_consume_out_valid", sbif.out_valid, 0);
        check("post_consume_in_ready", sbif.in_ready, 1);
        check("post_consume_busy", sbif.busy, 0);
    endtask

    task automatic do_txn(input string tag, input logic [127:0] d, input logic en,
                          input logic [127:0] exp, input int exp_lat);
        int lat;
        send(d, en);
        wait_out(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, sbif.byteSubData, exp);
        check({tag, "_in_ready"}, sbif.in_ready, 0);
        check({tag, "_busy"}, sbif.busy, 1);
        consume();
    endtask

    localparam logic [127:0] V_ZERO  = 128'h0;
    localparam logic [127:0] E_ZERO  = 128'h63636363_63636363_63636363_63636363;
    localparam logic [127:0] V_FIPS  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] E_FIPS  = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
    localparam logic [127:0] V_PASS  = 128'h01234567_89abcdef_fedcba98_76543210;

    initial begin
        int lat;
        int n_acc;
        int acc_cyc [2];
        logic acc;
        logic [127:0] held;

        sbif.inputData = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        sbif.enable    = 1'b1;
        sbif.in_valid  = 1'b1;
        sbif.out_ready = 1'b0;

        // Reset with a valid request pending: reset must win.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sbif.in_valid = 1'b0;
        check("rst_out_valid", sbif.out_valid, 0);
        check("rst_busy", sbif.busy, 0);
        check("rst_in_ready", sbif.in_ready, 1);
        check("rst_data", sbif.byteSubData, 128'h0);
        check("rst_state", dbg_state, 2'd0);

        do_txn("zero", V_ZERO, 1'b1, E_ZERO, 4);
        do_txn("fips", V_FIPS, 1'b1, E_FIPS, 4);
        do_txn("pass", V_PASS, 1'b0, V_PASS, 0);
        do_txn("ones", {128{1'b1}}, 1'b1, {16{8'h16}}, 4);

        // Back-pressure: result held, in_valid ignored while DONE.
        send(V_FIPS, 1'b1);
        wait_out(lat);
        check("bp_latency", lat, 4);
        held = sbif.byteSubData;
        check("bp_data", held, E_FIPS);
        sbif.in_valid  = 1'b1;
        sbif.inputData = V_PASS;
        sbif.enable    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_data", sbif.byteSubData, E_FIPS);
            check("bp_hold_valid", sbif.out_valid, 1);
            check("bp_hold_in_ready", sbif.in_ready, 0);
        end
        sbif.in_valid = 1'b0;
        consume();

        // Reset in the second SUB cycle discards the operation.
        send(V_FIPS, 1'b1);
        tick();
        check("mid_partial", sbif.byteSubData, 128'h00112233_44556677_8899aabb_4bc12816);
        check("mid_busy", sbif.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_data", sbif.byteSubData, 128'h0);
        check("mid_rst_in_ready", sbif.in_ready, 1);
        check("mid_rst_busy", sbif.busy, 0);
        for (int i = 0; i < 6; i++) begin
            check("mid_rst_no_valid", sbif.out_valid, 0);
            tick();
        end
        do_txn("after_rst", V_FIPS, 1'b1, E_FIPS, 4);

        // Back-to-back with in_valid held high and out_ready high.
        exp_q.push_back(E_ZERO);
        exp_q.push_back(E_FIPS);
        sbif.out_ready = 1'b1;
        sbif.inputData = V_ZERO;
        sbif.enable    = 1'b1;
        sbif.in_valid  = 1'b1;
        n_acc = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int cyc = 0; cyc < 60 && (n_acc < 2 || exp_q.size() != 0); cyc++) begin
            if (sbif.out_valid) begin
                if (exp_q.size() > 0) check("b2b_data", sbif.byteSubData, exp_q.pop_front());
                else check("b2b_extra_result", 1, 0);
            end
            acc = sbif.in_valid && sbif.in_ready;
            tick();
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) sbif.inputData = V_FIPS;
                else sbif.in_valid = 1'b0;
            end
        end
        check("b2b_accepts", n_acc, 2);
        check("b2b_gap", acc_cyc[1] - acc_cyc[0], 6);
        check("b2b_pending", exp_q.size(), 0);
        tick();
        sbif.out_ready = 1'b0;
        check("b2b_idle_in_ready", sbif.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
